// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF) and load/store (DM).
// DM has priority, bounded by a streak limit while IF waits, plus a watchdog that aborts stuck accesses.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;

  localparam logic [3:0] STREAK_LIM = 4'(MAX_STREAK);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

  state_t     state;
  logic [3:0] streak;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_next;
  logic       streak_full;
  logic       pick_dm;
  logic       pick_if;
  logic       acc_timeout;

  always_comb begin
    streak_full = (streak == STREAK_LIM);
    pick_dm     = dm_req & ~(if_req & streak_full);
    pick_if     = if_req & ~pick_dm;
    tmo_next    = tmo_cnt + 8'd1;
    acc_timeout = (tmo_next == TMO_LIM);
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      tmo_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_dm) begin
            state     <= DM_ACC;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            // Only DM grants that make a waiting fetch wait longer count toward the streak.
            if (!if_req)
              streak <= '0;
            else if (!streak_full)
              streak <= streak + 4'd1;
          end else if (pick_if) begin
            state     <= IF_ACC;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak    <= '0;
          end else begin
            streak <= '0;
          end
        end

        IF_ACC, DM_ACC: begin
          // Completion and watchdog abort share the exit path; an abort returns zero data.
          if (mem_ready || acc_timeout) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == IF_ACC) begin
              if_done  <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              dm_done  <= 1'b1;
              dm_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
            end
            if (!mem_ready)
              err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        RESP: begin
          // No grant here: the finished requester gets one cycle to drop its stale request.
          if_done <= 1'b0;
          dm_done <= 1'b0;
          tmo_cnt <= '0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXS = 4;
  localparam int TMO  = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          dm_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  typedef struct {
    bit          use_dm;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrdata;
    int          delay;
    logic [63:0] exp_rdata;
    int          exp_done_cyc;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction starting in an IDLE cycle; ends back in IDLE with requests dropped.
  task automatic xact(input vec_t v, input string nm);
    int t;
    bit seen;
    mem_ready = 1'b0;
    if (v.use_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chkb({nm, "_stall_c0"}, v.use_dm ? dm_stall : if_stall, 1'b1);
    chkb({nm, "_mem_req_c0"}, mem_req, 1'b0);
    step();
    t = 1;
    seen = 1'b0;
    while (!seen && t <= v.delay + 4) begin
      if (t == 1) begin
        chkb({nm, "_mem_req_c1"}, mem_req, 1'b1);
        chk({nm, "_mem_addr"}, mem_addr, v.addr);
        chkb({nm, "_mem_we"}, mem_we, v.we);
        if (v.we) chk({nm, "_mem_wdata"}, mem_wdata, v.wdata);
        chkb({nm, "_stall_c1"}, v.use_dm ? dm_stall : if_stall, 1'b1);
      end
      if (if_done || dm_done) begin
        seen = 1'b1;
        chk({nm, "_done_cycle"}, 64'(t), 64'(v.exp_done_cyc));
        chkb({nm, "_owner_dm"}, dm_done, v.use_dm);
        chkb({nm, "_owner_if"}, if_done, !v.use_dm);
        chk({nm, "_rdata"}, v.use_dm ? dm_rdata : if_rdata, v.exp_rdata);
        chkb({nm, "_stall_done"}, v.use_dm ? dm_stall : if_stall, 1'b0);
        chkb({nm, "_mem_req_done"}, mem_req, 1'b0);
      end else begin
        mem_ready = (t == v.delay + 1);
        mem_rdata = mem_ready ? v.mrdata : 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        t++;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_no_done: got no done within %0d cycles, expected done at cycle %0d",
               nm, v.delay + 4, v.exp_done_cyc);
    end
    mem_ready = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    step();
  endtask

  function automatic logic [63:0] rnd_addr();
    return 64'($urandom_range(0, 15)) << 3;
  endfunction

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
  endfunction

  logic [63:0] mem_model [logic [63:0]];

  initial begin
    vec_t        vecs [7];
    vec_t        sv;
    logic [9:0]  order_exp;
    int          g;
    int          cnt;
    bit          got_done;
    int          cyc, free_at, acc_start, ready_at, done_at, mstreak;
    bit          own_dm, e_we, in_acc, if_fin, dm_fin;
    logic [63:0] e_addr, e_wdata, e_rdata, word;

    vecs[0] = '{use_dm:1'b0, we:1'b0, addr:64'h40, wdata:64'h0, mrdata:64'h0000_0013,
                delay:0, exp_rdata:64'h13, exp_done_cyc:2};
    vecs[1] = '{use_dm:1'b1, we:1'b1, addr:64'h100, wdata:64'hDEAD_BEEF, mrdata:64'h5555_AAAA,
                delay:0, exp_rdata:64'h0, exp_done_cyc:2};
    vecs[2] = '{use_dm:1'b1, we:1'b0, addr:64'h200, wdata:64'h0, mrdata:64'hCAFE_F00D_1234_5678,
                delay:2, exp_rdata:64'hCAFE_F00D_1234_5678, exp_done_cyc:4};
    vecs[3] = '{use_dm:1'b0, we:1'b0, addr:64'hFFFF_FFFF_FFFF_FFF8, wdata:64'h0,
                mrdata:64'hFFFF_FFFF_FFFF_FFFF, delay:3, exp_rdata:64'hFFFF_FFFF_FFFF_FFFF,
                exp_done_cyc:5};
    vecs[4] = '{use_dm:1'b1, we:1'b1, addr:64'h8, wdata:64'h0123_4567_89AB_CDEF, mrdata:64'h1,
                delay:1, exp_rdata:64'h0, exp_done_cyc:3};
    vecs[5] = '{use_dm:1'b1, we:1'b0, addr:64'h0, wdata:64'h0, mrdata:64'h8000_0000_0000_0001,
                delay:1, exp_rdata:64'h8000_0000_0000_0001, exp_done_cyc:3};
    vecs[6] = '{use_dm:1'b0, we:1'b0, addr:64'h44, wdata:64'h0, mrdata:64'h7654_3210,
                delay:0, exp_rdata:64'h7654_3210, exp_done_cyc:2};

    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_mem_we", mem_we, 1'b0);
    chkb("rst_if_done", if_done, 1'b0);
    chkb("rst_dm_done", dm_done, 1'b0);
    chkb("rst_err", err, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_rdata_or", if_rdata | dm_rdata | mem_wdata, 64'h0);
    reset = 1'b1;
    step();

    // Reset asserted in the middle of a DM access.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h300; dm_wdata = 64'h1111_2222;
    step(); step(); step();
    chkb("midacc_mem_req", mem_req, 1'b1);
    chkb("midacc_mem_we", mem_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    chkb("async_rst_mem_req", mem_req, 1'b0);
    chkb("async_rst_mem_we", mem_we, 1'b0);
    chk("async_rst_mem_addr", mem_addr, 64'h0);
    chk("async_rst_mem_wdata", mem_wdata, 64'h0);
    dm_req = 1'b0;
    step();
    reset = 1'b1;
    got_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dm_done || if_done || mem_req) got_done = 1'b1;
    end
    chkb("post_rst_no_activity", got_done, 1'b0);

    // Vector table: isolated transactions.
    for (int i = 0; i < 7; i++) xact(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held: DM streak is capped, then IF gets a turn.
    order_exp = 10'b0111101111;
    g = 0;
    if_addr = 64'h1000; dm_addr = 64'h2000; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    mem_ready = 1'b1; mem_rdata = 64'h55;
    for (int c = 0; c < 60 && g < 10; c++) begin
      step();
      chkb("both_done", if_done & dm_done, 1'b0);
      if (mem_req) begin
        chkb($sformatf("grant%0d_is_dm", g), mem_addr == 64'h2000, order_exp[g]);
        g++;
      end
    end
    chk("grant_count", 64'(g), 64'd10);
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    step(); step();

    // Stray mem_ready while idle must not complete a later fetch.
    mem_ready = 1'b1; mem_rdata = 64'hDEAD_0000_0000_0BAD;
    step(); step();
    sv = '{use_dm:1'b0, we:1'b0, addr:64'h80, wdata:64'h0, mrdata:64'h77,
           delay:2, exp_rdata:64'h77, exp_done_cyc:4};
    xact(sv, "stray_ready");

    // Watchdog abort with mem_ready held low.
    chkb("err_before_tmo", err, 1'b0);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h500;
    mem_ready = 1'b0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    cnt = 0;
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      if (dm_done) got_done = 1'b1;
      else begin
        if (mem_req) cnt++;
        step();
      end
    end
    chkb("tmo_done_seen", got_done, 1'b1);
    chk("tmo_req_cycles", 64'(cnt), 64'(TMO));
    chk("tmo_dm_rdata", dm_rdata, 64'h0);
    chkb("tmo_err", err, 1'b1);
    chkb("tmo_no_if_done", if_done, 1'b0);
    dm_req = 1'b0;
    step(); step(); step();
    chkb("err_sticky_idle", err, 1'b1);
    xact(vecs[6], "after_tmo");
    chkb("err_sticky_xact", err, 1'b1);
    reset = 1'b0;
    #1;
    chkb("err_cleared_by_rst", err, 1'b0);
    step();
    reset = 1'b1;
    step();

    // Randomized traffic against a transaction-level model.
    free_at = 0; acc_start = -1; ready_at = -1; done_at = -1; mstreak = 0;
    own_dm = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      chkb("rnd_mem_req", mem_req, acc_start >= 0 && cyc >= acc_start && cyc <= ready_at);
      if (cyc == acc_start) begin
        chk("rnd_mem_addr", mem_addr, e_addr);
        chkb("rnd_mem_we", mem_we, e_we);
        if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wdata);
      end
      chkb("rnd_if_done", if_done, cyc == done_at && !own_dm);
      chkb("rnd_dm_done", dm_done, cyc == done_at && own_dm);
      if (cyc == done_at)
        chk("rnd_rdata", own_dm ? dm_rdata : if_rdata, e_rdata);

      if_fin = (cyc == done_at) && !own_dm;
      dm_fin = (cyc == done_at) && own_dm;
      if (if_req) begin
        if (if_fin) begin
          if_req = 1'($urandom_range(0, 1));
          if_addr = rnd_addr();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = rnd_addr();
      end
      if (dm_req) begin
        if (dm_fin) begin
          dm_req = 1'($urandom_range(0, 1));
          dm_we = 1'($urandom_range(0, 1));
          dm_addr = rnd_addr();
          dm_wdata = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = rnd_addr();
        dm_wdata = {$urandom, $urandom};
      end
      #1;
      chkb("rnd_if_stall", if_stall, if_req && !if_fin);
      chkb("rnd_dm_stall", dm_stall, dm_req && !dm_fin);

      if (cyc == free_at) begin
        if (!if_req) mstreak = 0;
        if (dm_req && !(if_req && mstreak == MAXS)) begin
          own_dm = 1'b1; e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
          if (if_req && mstreak < MAXS) mstreak++;
        end else if (if_req) begin
          own_dm = 1'b0; e_we = 1'b0; e_addr = if_addr; e_wdata = '0;
          mstreak = 0;
        end
        if (dm_req || if_req) begin
          acc_start = cyc + 1;
          ready_at = acc_start + int'($urandom_range(0, 3));
          done_at = ready_at + 1;
          free_at = ready_at + 2;
        end else begin
          free_at = cyc + 1;
        end
      end

      in_acc = acc_start >= 0 && cyc >= acc_start && cyc <= ready_at;
      if (cyc == ready_at) begin
        word = mem_model.exists(e_addr) ? mem_model[e_addr] : init_word(e_addr);
        mem_ready = 1'b1;
        mem_rdata = word;
        if (e_we) begin
          mem_model[e_addr] = e_wdata;
          e_rdata = '0;
        end else begin
          e_rdata = word;
        end
      end else if (in_acc) begin
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
    end
    chkb("rnd_no_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
